// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor drive stage.
package mtr_drv_pkg;

  localparam int unsigned SPD_W   = 12;
  localparam int unsigned DUTY_W  = 11;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned BLANK_W = 8;
  localparam int unsigned OVR_W   = 8;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam logic [CNT_W-1:0]   NONOVERLAP_DFLT  = 11'h040;
  localparam logic [BLANK_W-1:0] BLANK_LEN_DFLT   = 8'd128;
  localparam logic [OVR_W-1:0]   OVR_I_LIMIT_DFLT = 8'd15;

  localparam logic signed [SPD_W-1:0] SPD_MAX  = 12'sd1023;
  localparam logic signed [SPD_W-1:0] SPD_MIN  = -12'sd1024;
  localparam logic signed [SPD_W-1:0] DUTY_OFS = 12'sd1024;

  localparam duty_t DUTY_RST = 11'h400;

  // Clamp a signed speed to the 11-bit signed range and offset it to an unsigned duty.
  function automatic duty_t spd_to_duty(input logic signed [SPD_W-1:0] spd);
    logic signed [SPD_W-1:0] sat;
    if (spd > SPD_MAX) begin
      sat = SPD_MAX;
    end else if (spd < SPD_MIN) begin
      sat = SPD_MIN;
    end else begin
      sat = spd;
    end
    return DUTY_W'(sat + DUTY_OFS);
  endfunction

endpackage

// File: rtl/pwm11.sv
// One H-bridge half: complementary non-overlapping 11-bit PWM plus the
// over-current blanking window around both switching edges.
module pwm11
  import mtr_drv_pkg::*;
#(
  parameter logic [CNT_W-1:0]   NONOVERLAP = NONOVERLAP_DFLT,
  parameter logic [BLANK_W-1:0] BLANK_LEN  = BLANK_LEN_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  duty_t            duty,
  input  logic [CNT_W-1:0] cnt,
  output logic             PWM1,
  output logic             PWM2,
  output logic             ovr_I_blank
);

  localparam int unsigned EXT_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             pwm1_q, pwm1_d;
  logic             pwm2_q, pwm2_d;
  logic [EXT_W-1:0] cnt_x;
  logic [EXT_W-1:0] duty_x;
  logic [EXT_W-1:0] lead_x;
  logic [EXT_W-1:0] blk_a_lo;
  logic [EXT_W-1:0] blk_a_hi;
  logic [EXT_W-1:0] blk_b_hi;

  // Widen to 12 bits so duty+NONOVERLAP past 2047 simply never matches.
  assign cnt_x    = EXT_W'(cnt);
  assign duty_x   = EXT_W'(duty);
  assign lead_x   = duty_x + EXT_W'(NONOVERLAP);
  assign blk_a_lo = EXT_W'(NONOVERLAP);
  assign blk_a_hi = blk_a_lo + EXT_W'(BLANK_LEN);
  assign blk_b_hi = lead_x + EXT_W'(BLANK_LEN);

  // Next-state for both drive phases; clear takes priority over set.
  always_comb begin
    pwm2_d = pwm2_q;
    pwm1_d = pwm1_q;
    if (cnt == NONOVERLAP) begin
      pwm2_d = 1'b1;
    end
    if (cnt_x >= duty_x) begin
      pwm2_d = 1'b0;
    end
    if (cnt_x >= lead_x) begin
      pwm1_d = 1'b1;
    end
    if (cnt == CNT_MAX) begin
      pwm1_d = 1'b0;
    end
  end

  // Drive phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm1_q <= 1'b0;
      pwm2_q <= 1'b0;
    end else begin
      pwm1_q <= pwm1_d;
      pwm2_q <= pwm2_d;
    end
  end

  assign PWM1 = pwm1_q;
  assign PWM2 = pwm2_q;

  // Comparator is ignored just after each turn-on edge while the bridge rings.
  assign ovr_I_blank = ((cnt_x > blk_a_lo) && (cnt_x < blk_a_hi)) ||
                       ((cnt_x > lead_x)   && (cnt_x < blk_b_hi));

endmodule

// File: rtl/mtr_drv.sv
// Motor drive stage: speed-to-duty saturation, shared PWM period counter,
// two PWM halves, over-current qualification and sticky shutdown.
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter logic [CNT_W-1:0]   NONOVERLAP  = NONOVERLAP_DFLT,
  parameter logic [BLANK_W-1:0] BLANK_LEN   = BLANK_LEN_DFLT,
  parameter logic [OVR_W-1:0]   OVR_I_LIMIT = OVR_I_LIMIT_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SPD_W-1:0] lft_spd,
  input  logic [SPD_W-1:0] rght_spd,
  input  logic             OVR_I_lft,
  input  logic             OVR_I_rght,
  output logic             PWM1_lft,
  output logic             PWM2_lft,
  output logic             PWM1_rght,
  output logic             PWM2_rght,
  output logic             OVR_I_shtdwn
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [OVR_W-1:0] OVR_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  duty_t            duty_lft_q, duty_lft_d;
  duty_t            duty_rght_q, duty_rght_d;
  logic             ovr_lft_meta_q, ovr_lft_sync_q;
  logic             ovr_rght_meta_q, ovr_rght_sync_q;
  logic             ovr_flag_q, ovr_flag_d;
  logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic             shtdwn_q, shtdwn_d;

  logic             pwm_synch_c;
  logic             ovr_evt_c;
  logic             pwm1_lft, pwm2_lft, blank_lft;
  logic             pwm1_rght, pwm2_rght, blank_rght;

  assign pwm_synch_c = (cnt_q == '0);

  // Over-current only counts while the high side conducts outside blanking.
  assign ovr_evt_c = (ovr_lft_sync_q  & ~blank_lft  & pwm1_lft) |
                     (ovr_rght_sync_q & ~blank_rght & pwm1_rght);

  // Period counter, duty reload at the period boundary, over-current tally.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    duty_lft_d  = duty_lft_q;
    duty_rght_d = duty_rght_q;
    ovr_flag_d  = ovr_flag_q | ovr_evt_c;
    ovr_cnt_d   = ovr_cnt_q;
    shtdwn_d    = shtdwn_q | (ovr_cnt_q >= OVR_I_LIMIT);

    if (pwm_synch_c) begin
      duty_lft_d  = spd_to_duty($signed(lft_spd));
      duty_rght_d = spd_to_duty($signed(rght_spd));
    end

    if (cnt_q == CNT_MAX) begin
      ovr_flag_d = 1'b0;
      if (ovr_flag_q | ovr_evt_c) begin
        if (ovr_cnt_q != OVR_MAX) begin
          ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
        end
      end else begin
        ovr_cnt_d = '0;
      end
    end
  end

  // Main state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      duty_lft_q  <= DUTY_RST;
      duty_rght_q <= DUTY_RST;
      ovr_flag_q  <= 1'b0;
      ovr_cnt_q   <= '0;
      shtdwn_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      duty_lft_q  <= duty_lft_d;
      duty_rght_q <= duty_rght_d;
      ovr_flag_q  <= ovr_flag_d;
      ovr_cnt_q   <= ovr_cnt_d;
      shtdwn_q    <= shtdwn_d;
    end
  end

  // Two-flop synchronisers for the raw comparator inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_lft_meta_q  <= 1'b0;
      ovr_lft_sync_q  <= 1'b0;
      ovr_rght_meta_q <= 1'b0;
      ovr_rght_sync_q <= 1'b0;
    end else begin
      ovr_lft_meta_q  <= OVR_I_lft;
      ovr_lft_sync_q  <= ovr_lft_meta_q;
      ovr_rght_meta_q <= OVR_I_rght;
      ovr_rght_sync_q <= ovr_rght_meta_q;
    end
  end

  pwm11 #(
    .NONOVERLAP (NONOVERLAP),
    .BLANK_LEN  (BLANK_LEN)
  ) u_pwm_lft (
    .clk         (clk),
    .rst_n       (rst_n),
    .duty        (duty_lft_q),
    .cnt         (cnt_q),
    .PWM1        (pwm1_lft),
    .PWM2        (pwm2_lft),
    .ovr_I_blank (blank_lft)
  );

  pwm11 #(
    .NONOVERLAP (NONOVERLAP),
    .BLANK_LEN  (BLANK_LEN)
  ) u_pwm_rght (
    .clk         (clk),
    .rst_n       (rst_n),
    .duty        (duty_rght_q),
    .cnt         (cnt_q),
    .PWM1        (pwm1_rght),
    .PWM2        (pwm2_rght),
    .ovr_I_blank (blank_rght)
  );

  // Shutdown gates the drive flops directly so the bridge is off the same cycle.
  assign PWM1_lft     = pwm1_lft  & ~shtdwn_q;
  assign PWM2_lft     = pwm2_lft  & ~shtdwn_q;
  assign PWM1_rght    = pwm1_rght & ~shtdwn_q;
  assign PWM2_rght    = pwm2_rght & ~shtdwn_q;
  assign OVR_I_shtdwn = shtdwn_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv with an expected-value scoreboard.
module tb_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] lft_spd, rght_spd;
  logic        OVR_I_lft, OVR_I_rght;
  logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, OVR_I_shtdwn;

  mtr_drv dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .PWM1_lft     (PWM1_lft),
    .PWM2_lft     (PWM2_lft),
    .PWM1_rght    (PWM1_rght),
    .PWM2_rght    (PWM2_rght),
    .OVR_I_shtdwn (OVR_I_shtdwn)
  );

  always #10 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pos         = 0;   // counter value the DUT should hold right now
  int   first_h[4], last_h[4], cnt_h[4];
  int   ovl_l, ovl_r;
  int   wa[3], wb[3];      // OVR_I_lft high windows (raw, inclusive)
  int   chg_pos = -1;
  logic [11:0] chg_val = 12'h000;

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] observed);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed %0d", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === 32'(e.val)) else begin
        miscompares++;
        $error("FAIL %s observed %0d expected %0d", e.tag, observed, e.val);
      end
    end
  endtask

  function automatic int exp_duty(input logic [11:0] spd);
    int v;
    v = int'($signed(spd));
    if (v > 1023)  v = 1023;
    if (v < -1024) v = -1024;
    return v + 1024;
  endfunction

  // Expected high interval of each phase for a given duty, as sampled at cnt.
  task automatic push_side(input string tag, input int duty);
    int lead;
    lead = duty + 64;
    if (lead >= 2047) begin
      push({tag, "_pwm1_first"}, -1); push({tag, "_pwm1_last"}, -1); push({tag, "_pwm1_cnt"}, 0);
    end else begin
      push({tag, "_pwm1_first"}, lead + 1); push({tag, "_pwm1_last"}, 2047);
      push({tag, "_pwm1_cnt"}, 2047 - lead);
    end
    if (duty <= 64) begin
      push({tag, "_pwm2_first"}, -1); push({tag, "_pwm2_last"}, -1); push({tag, "_pwm2_cnt"}, 0);
    end else begin
      push({tag, "_pwm2_first"}, 65); push({tag, "_pwm2_last"}, duty);
      push({tag, "_pwm2_cnt"}, duty - 64);
    end
  endtask

  task automatic push_pwm(input string tag, input int dl, input int dr);
    push_side({tag, "_lft"}, dl);
    push_side({tag, "_rght"}, dr);
    push({tag, "_ovl_lft"}, 0);
    push({tag, "_ovl_rght"}, 0);
  endtask

  task automatic push_off(input string tag);
    for (int s = 0; s < 4; s++) begin
      push($sformatf("%s_out%0d_first", tag, s), -1);
      push($sformatf("%s_out%0d_last", tag, s), -1);
      push($sformatf("%s_out%0d_cnt", tag, s), 0);
    end
    push({tag, "_ovl_lft"}, 0);
    push({tag, "_ovl_rght"}, 0);
  endtask

  task automatic cmp_pwm();
    for (int s = 0; s < 4; s++) begin
      check(32'(first_h[s]));
      check(32'(last_h[s]));
      check(32'(cnt_h[s]));
    end
    check(32'(ovl_l));
    check(32'(ovl_r));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    pos = (pos + 1) % 2048;
  endtask

  function automatic logic in_win(input int p);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < 3; w++) begin
      if (p >= wa[w] && p <= wb[w]) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic set_win(input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2);
    wa[0] = a0; wb[0] = b0;
    wa[1] = a1; wb[1] = b1;
    wa[2] = a2; wb[2] = b2;
  endtask

  // Runs one full period starting at cnt 0, recording each output's high span.
  task automatic run_period();
    logic [3:0] o;
    for (int s = 0; s < 4; s++) begin
      first_h[s] = -1; last_h[s] = -1; cnt_h[s] = 0;
    end
    ovl_l = 0;
    ovl_r = 0;
    for (int k = 0; k < 2048; k++) begin
      o = {PWM2_rght, PWM1_rght, PWM2_lft, PWM1_lft};
      for (int s = 0; s < 4; s++) begin
        if (o[s] === 1'b1) begin
          if (first_h[s] == -1) first_h[s] = pos;
          last_h[s] = pos;
          cnt_h[s]++;
        end
      end
      if (PWM1_lft === 1'b1 && PWM2_lft === 1'b1) ovl_l++;
      if (PWM1_rght === 1'b1 && PWM2_rght === 1'b1) ovl_r++;
      OVR_I_lft = in_win(pos);
      if (pos == chg_pos) lft_spd = chg_val;
      tick();
    end
  endtask

  task automatic oc_periods(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      run_period();
      push($sformatf("%s_shtdwn_p%0d", tag, i), 0);
      check(32'(OVR_I_shtdwn));
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog expired at pos %0d", pos);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    lft_spd    = 12'h000;
    rght_spd   = 12'h7FF;
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
    set_win(-1, -1, -1, -1, -1, -1);
    repeat (3) @(negedge clk);

    push("rst_pwm1_lft", 0);  check(32'(PWM1_lft));
    push("rst_pwm2_lft", 0);  check(32'(PWM2_lft));
    push("rst_pwm1_rght", 0); check(32'(PWM1_rght));
    push("rst_pwm2_rght", 0); check(32'(PWM2_rght));
    push("rst_shtdwn", 0);    check(32'(OVR_I_shtdwn));

    rst_n = 1'b1;
    pos   = 0;

    // Mid-scale left, positive-saturated right.
    push_pwm("p0", exp_duty(12'h000), exp_duty(12'h7FF));
    run_period();
    cmp_pwm();

    // Negative-saturated left, mid-scale right.
    lft_spd  = 12'h900;
    rght_spd = 12'h000;
    push_pwm("p1", exp_duty(12'h900), exp_duty(12'h000));
    run_period();
    cmp_pwm();

    // Speed change mid-period must not disturb the current period.
    lft_spd  = 12'h100;
    rght_spd = 12'h800;
    chg_pos  = 500;
    chg_val  = 12'hF00;
    push_pwm("p2", exp_duty(12'h100), exp_duty(12'h800));
    run_period();
    cmp_pwm();
    chg_pos = -1;
    push_pwm("p3", exp_duty(12'hF00), exp_duty(12'h800));
    run_period();
    cmp_pwm();

    // Pulses confined to the turn-on blank window with PWM1 already high.
    lft_spd  = 12'h800;
    rght_spd = 12'h000;
    set_win(70, 180, -1, -1, -1, -1);
    oc_periods("blank", 3);

    // Qualified over-current for 9 periods, then a period with only blanked pulses.
    lft_spd = 12'h000;
    set_win(70, 180, 1100, 1200, 1500, 1600);
    oc_periods("oc_a", 9);
    set_win(70, 180, 1100, 1200, -1, -1);
    oc_periods("clean", 1);

    // Fresh run of 15 qualified periods trips the shutdown.
    set_win(70, 180, 1100, 1200, 1500, 1600);
    oc_periods("oc_b", 15);
    set_win(-1, -1, -1, -1, -1, -1);
    OVR_I_lft = 1'b0;
    tick();
    push("trip_shtdwn", 1);     check(32'(OVR_I_shtdwn));
    push("trip_pwm1_lft", 0);   check(32'(PWM1_lft));
    push("trip_pwm2_lft", 0);   check(32'(PWM2_lft));
    push("trip_pwm1_rght", 0);  check(32'(PWM1_rght));
    push("trip_pwm2_rght", 0);  check(32'(PWM2_rght));
    while (pos != 0) tick();

    // Shutdown is sticky and holds every output low for a whole period.
    push_off("off");
    run_period();
    cmp_pwm();
    push("off_shtdwn", 1);
    check(32'(OVR_I_shtdwn));

    // Asynchronous reset mid-period clears the shutdown without a clock edge.
    while (pos != 1000) tick();
    #3;
    rst_n = 1'b0;
    #1;
    push("arst_shtdwn", 0);    check(32'(OVR_I_shtdwn));
    push("arst_pwm2_lft", 0);  check(32'(PWM2_lft));
    push("arst_pwm1_rght", 0); check(32'(PWM1_rght));
    @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;
    while (pos != 100) tick();
    push("post_rst_pwm2_lft", 1); check(32'(PWM2_lft));
    push("post_rst_pwm1_lft", 0); check(32'(PWM1_lft));
    push("post_rst_shtdwn", 0);   check(32'(OVR_I_shtdwn));

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
